nx_stream_distributor_buf: RTL and testbench
============================================

// Module: nx_stream_distributor_buf
//
// PURPOSE
//   Parametrised, buffered successor to the 4-way stream distributor. Routes each
//   inbound message to one of CHANNELS outbound streams selected by dist_dir_i, or
//   to all channels when dist_bcast_i is set. A per-channel FIFO decouples the
//   outputs, so one stalled output does not block traffic to the others.
//   Sits between a node's message source and its mesh-facing egress ports.
//
// PARAMETERS
//   STREAM_WIDTH  32  message payload width in bits
//   CHANNELS      4   number of outbound streams (>=2); index 0..3 = N,E,S,W when 4
//   DEPTH         2   entries per channel FIFO (power of 2, >=2)
//   DIR_WIDTH     $clog2(CHANNELS)  width of the direction select (derived)
//
// PORTS
//   clk_i         in   1                      clock
//   rst_i         in   1                      reset, asynchronous, active-high
//   dist_data_i   in   STREAM_WIDTH           inbound payload
//   dist_dir_i    in   DIR_WIDTH              target channel index
//   dist_bcast_i  in   1                      1 = deliver to every channel
//   dist_valid_i  in   1                      inbound valid
//   dist_ready_o  out  1                      inbound ready
//   out_data_o    out  CHANNELS*STREAM_WIDTH  outbound payloads, channel c at [c*SW +: SW]
//   out_valid_o   out  CHANNELS               outbound valid per channel
//   out_ready_i   in   CHANNELS               outbound ready per channel
//   drop_o        out  1                      1-cycle pulse: message dropped (bad dir)
//   idle_o        out  1                      all channel FIFOs empty
//
// BEHAVIOUR
//   - Reset (async assert, sync release on clk_i): all FIFOs emptied, pointers and
//     occupancy 0; out_valid_o=0, drop_o=0, idle_o=1, out_data_o=0.
//   - Reset mid-operation discards all buffered messages; nothing is re-emitted.
//   - Handshake: transfer occurs on the rising edge where valid && ready. Valid must
//     hold with stable data until accepted (inbound); same rule applies outbound.
//   - dist_ready_o (combinational from dir/bcast and registered full flags only):
//       bcast=1           -> 1 iff no channel FIFO is full
//       bcast=0, dir<CH   -> !full[dir]
//       bcast=0, dir>=CH  -> 1 (message consumed and discarded)
//     dist_ready_o never depends on out_ready_i: a full FIFO being popped this
//     cycle still reports not-ready (no ready-to-ready combinational path).
//   - Broadcast is atomic: written to all CHANNELS FIFOs on the same edge, or none.
//   - Bad dir (bcast=0, dir>=CHANNELS, non-power-of-2 CHANNELS only): accepted,
//     not stored, drop_o pulses high the following cycle.
//   - Latency: message accepted at edge N appears on out_valid_o[c] after edge N
//     (first cycle N+1); no same-cycle fall-through.
//   - Per-channel FIFO: out_valid_o[c] = !empty[c]; out_data_o slice = head entry;
//     pop on out_valid_o[c] && out_ready_i[c]. Order preserved per channel.
//   - Simultaneous push and pop on same channel: both take effect, occupancy
//     unchanged; legal at any non-full occupancy (push only when !full).
//   - Pointers are log2(DEPTH) bits and wrap modulo DEPTH; occupancy counter is
//     log2(DEPTH)+1 bits, range 0..DEPTH; full = (occ==DEPTH), empty = (occ==0).
//   - idle_o = AND over channels of empty[c], registered-state derived (no input path).
//
// TESTING
//   1. Reset, then send 0xA5 with dir=2, bcast=0 -> out_valid_o=4'b0100 from next
//      cycle, slice 2 = 0xA5; idle_o drops to 0, returns to 1 after pop.
//   2. Hold out_ready_i[1]=0, send 3 msgs to dir=1 (DEPTH=2) -> first two accepted,
//      dist_ready_o=0 on third; msgs to dir=0 still accepted and delivered.
//   3. Broadcast 0x1234 with channel 3 full -> dist_ready_o=0, no channel written;
//      after channel 3 pops one, broadcast lands in all 4 FIFOs on one edge.
//   4. Channel 0 full and popped same cycle as new msg for dir=0 -> dist_ready_o=0
//      that cycle; accepted next cycle; order 1,2,3 preserved on output.
//   5. CHANNELS=3, send dir=3, bcast=0 -> dist_ready_o=1, no out_valid_o, drop_o
//      high exactly one cycle.
//   6. Fill several FIFOs, assert rst_i mid-cycle -> out_valid_o=0 immediately,
//      idle_o=1; after release, no stale message emitted.

Source files
------------

// File: rtl/nx_stream_distributor_buf.sv
// nx_stream_distributor_buf
//   Routes each inbound message to one of CHANNELS outbound streams (dist_dir_i),
//   or to all of them (dist_bcast_i), through a per-channel FIFO so that a stalled
//   output does not block traffic to the other outputs.
//
// Ports
//   clk_i, rst_i   clock, asynchronous active-high reset
//   dist_*         inbound valid/ready stream with payload, direction and broadcast flag
//   out_data_o     outbound payloads, channel c at [c*STREAM_WIDTH +: STREAM_WIDTH]
//   out_valid_o    per-channel valid (FIFO not empty)
//   out_ready_i    per-channel ready
//   drop_o         one-cycle pulse after a message with an out-of-range direction is consumed
//   idle_o         all channel FIFOs empty
module nx_stream_distributor_buf #(
   parameter int unsigned STREAM_WIDTH = 32,
   parameter int unsigned CHANNELS     = 4,
   parameter int unsigned DEPTH        = 2,
   parameter int unsigned DIR_WIDTH    = $clog2(CHANNELS)
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic [STREAM_WIDTH-1:0]          dist_data_i,
   input  logic [DIR_WIDTH-1:0]             dist_dir_i,
   input  logic                             dist_bcast_i,
   input  logic                             dist_valid_i,
   output logic                             dist_ready_o,
   output logic [CHANNELS*STREAM_WIDTH-1:0] out_data_o,
   output logic [CHANNELS-1:0]              out_valid_o,
   input  logic [CHANNELS-1:0]              out_ready_i,
   output logic                             drop_o,
   output logic                             idle_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned OCC_W = PTR_W + 1;
   localparam int unsigned PAD_W = 1 << DIR_WIDTH;

   logic [CHANNELS-1:0] full;
   logic [CHANNELS-1:0] empty;
   logic [CHANNELS-1:0] push;
   logic [CHANNELS-1:0] pop;
   logic [PAD_W-1:0]    full_pad;
   logic                dir_ok;
   logic                accept;
   logic                drop_q;

   // Inbound ready: depends only on dir/bcast and registered full flags, never on out_ready_i.
   always_comb begin
      full_pad     = PAD_W'(full);
      dir_ok       = (32'(dist_dir_i) < CHANNELS);
      dist_ready_o = 1'b1;
      if (dist_bcast_i) begin
         dist_ready_o = ~|full;
      end else if (dir_ok) begin
         dist_ready_o = ~full_pad[dist_dir_i];
      end
   end

   assign accept = dist_valid_i & dist_ready_o;

   // One FIFO per outbound channel; broadcast pushes every channel on the same edge.
   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [STREAM_WIDTH-1:0] mem [DEPTH];
      logic [PTR_W-1:0]        wr_ptr;
      logic [PTR_W-1:0]        rd_ptr;
      logic [OCC_W-1:0]        occ;

      assign full[c]        = (occ == OCC_W'(DEPTH));
      assign empty[c]       = (occ == '0);
      assign push[c]        = accept & (dist_bcast_i | (dir_ok & (dist_dir_i == DIR_WIDTH'(c))));
      assign pop[c]         = ~empty[c] & out_ready_i[c];
      assign out_valid_o[c] = ~empty[c];
      assign out_data_o[c*STREAM_WIDTH +: STREAM_WIDTH] = mem[rd_ptr];

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
               mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
         end else begin
            if (push[c]) begin
               mem[wr_ptr] <= dist_data_i;
               wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop[c]) begin
               rd_ptr <= rd_ptr + PTR_W'(1);
            end
            occ <= occ + OCC_W'(push[c]) - OCC_W'(pop[c]);
         end
      end
   end

   // Out-of-range direction: consumed without storing, flagged one cycle later.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         drop_q <= 1'b0;
      end else begin
         drop_q <= accept & ~dist_bcast_i & ~dir_ok;
      end
   end

   assign drop_o = drop_q;
   assign idle_o = &empty;

endmodule

// File: tb/tb_nx_stream_distributor_buf.sv
// Directed bench for nx_stream_distributor_buf: a 4-channel instance for routing,
// backpressure, broadcast and reset, plus a 3-channel instance for the drop path.
module tb_nx_stream_distributor_buf;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] data = '0;
   logic [1:0]  dir = '0;
   logic        bcast = 1'b0;
   logic        valid = 1'b0;
   logic        ready;
   logic [127:0] odata;
   logic [3:0]  ovalid;
   logic [3:0]  oready = '0;
   logic        drop;
   logic        idle;

   logic [1:0]  dir3 = '0;
   logic        valid3 = 1'b0;
   logic        ready3;
   logic [95:0] odata3;
   logic [2:0]  ovalid3;
   logic        drop3;
   logic        idle3;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   nx_stream_distributor_buf #(.STREAM_WIDTH(32), .CHANNELS(4), .DEPTH(2)) dut (
      .clk_i(clk), .rst_i(rst), .dist_data_i(data), .dist_dir_i(dir),
      .dist_bcast_i(bcast), .dist_valid_i(valid), .dist_ready_o(ready),
      .out_data_o(odata), .out_valid_o(ovalid), .out_ready_i(oready),
      .drop_o(drop), .idle_o(idle)
   );

   nx_stream_distributor_buf #(.STREAM_WIDTH(32), .CHANNELS(3), .DEPTH(2)) dut3 (
      .clk_i(clk), .rst_i(rst), .dist_data_i(data), .dist_dir_i(dir3),
      .dist_bcast_i(1'b0), .dist_valid_i(valid3), .dist_ready_o(ready3),
      .out_data_o(odata3), .out_valid_o(ovalid3), .out_ready_i(3'b000),
      .drop_o(drop3), .idle_o(idle3)
   );

   // Advance past the next rising edge; inputs change and outputs are sampled here.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      cyc();
      cyc();
      total++; if (ovalid !== 4'b0000) begin bad++; $display("FAIL rst_valid got=%b exp=0000", ovalid); end
      total++; if (idle !== 1'b1) begin bad++; $display("FAIL rst_idle got=%b exp=1", idle); end
      total++; if (odata !== 128'h0) begin bad++; $display("FAIL rst_data got=%h exp=0", odata); end
      total++; if (drop !== 1'b0) begin bad++; $display("FAIL rst_drop got=%b exp=0", drop); end
      rst = 1'b0;
      cyc();
   endtask

   task automatic test_single();
      data = 32'hA5; dir = 2'd2; bcast = 1'b0; valid = 1'b1;
      #1;
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL single_ready got=%b exp=1", ready); end
      total++; if (ovalid !== 4'b0000) begin bad++; $display("FAIL single_nofall got=%b exp=0000", ovalid); end
      cyc();
      valid = 1'b0;
      total++; if (ovalid !== 4'b0100) begin bad++; $display("FAIL single_valid got=%b exp=0100", ovalid); end
      total++; if (odata[64 +: 32] !== 32'hA5) begin bad++; $display("FAIL single_data got=%h exp=a5", odata[64 +: 32]); end
      total++; if (idle !== 1'b0) begin bad++; $display("FAIL single_busy got=%b exp=0", idle); end
      oready = 4'b0100;
      cyc();
      oready = 4'b0000;
      total++; if (ovalid !== 4'b0000) begin bad++; $display("FAIL single_pop got=%b exp=0000", ovalid); end
      total++; if (idle !== 1'b1) begin bad++; $display("FAIL single_idle got=%b exp=1", idle); end
   endtask

   task automatic test_backpressure();
      dir = 2'd1; valid = 1'b1; data = 32'h11;
      cyc();
      data = 32'h22;
      cyc();
      data = 32'h33;
      #1;
      total++; if (ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%b exp=0", ready); end
      cyc();
      dir = 2'd0; data = 32'h44;
      #1;
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL bp_other_ready got=%b exp=1", ready); end
      cyc();
      valid = 1'b0;
      total++; if (ovalid !== 4'b0011) begin bad++; $display("FAIL bp_valid got=%b exp=0011", ovalid); end
      total++; if (odata[0 +: 32] !== 32'h44) begin bad++; $display("FAIL bp_ch0 got=%h exp=44", odata[0 +: 32]); end
      total++; if (odata[32 +: 32] !== 32'h11) begin bad++; $display("FAIL bp_ch1_head got=%h exp=11", odata[32 +: 32]); end
      oready = 4'b0011;
      cyc();
      total++; if (ovalid !== 4'b0010) begin bad++; $display("FAIL bp_drain1 got=%b exp=0010", ovalid); end
      total++; if (odata[32 +: 32] !== 32'h22) begin bad++; $display("FAIL bp_ch1_next got=%h exp=22", odata[32 +: 32]); end
      cyc();
      oready = 4'b0000;
      total++; if (ovalid !== 4'b0000) begin bad++; $display("FAIL bp_drain2 got=%b exp=0000", ovalid); end
   endtask

   task automatic test_broadcast();
      dir = 2'd3; valid = 1'b1; data = 32'h31;
      cyc();
      data = 32'h32;
      cyc();
      bcast = 1'b1; data = 32'h1234;
      #1;
      total++; if (ready !== 1'b0) begin bad++; $display("FAIL bc_blocked got=%b exp=0", ready); end
      cyc();
      total++; if (ovalid !== 4'b1000) begin bad++; $display("FAIL bc_nowrite got=%b exp=1000", ovalid); end
      oready = 4'b1000;
      #1;
      total++; if (ready !== 1'b0) begin bad++; $display("FAIL bc_popcycle got=%b exp=0", ready); end
      cyc();
      oready = 4'b0000;
      #1;
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL bc_ready got=%b exp=1", ready); end
      cyc();
      valid = 1'b0; bcast = 1'b0;
      total++; if (ovalid !== 4'b1111) begin bad++; $display("FAIL bc_all got=%b exp=1111", ovalid); end
      total++; if (odata[95:0] !== {3{32'h1234}}) begin bad++; $display("FAIL bc_data got=%h exp=3x1234", odata[95:0]); end
      total++; if (odata[96 +: 32] !== 32'h32) begin bad++; $display("FAIL bc_ch3_head got=%h exp=32", odata[96 +: 32]); end
      oready = 4'b1111;
      cyc();
      total++; if (ovalid !== 4'b1000 || odata[96 +: 32] !== 32'h1234) begin
         bad++; $display("FAIL bc_ch3_tail got=%b/%h exp=1000/1234", ovalid, odata[96 +: 32]);
      end
      cyc();
      oready = 4'b0000;
      total++; if (ovalid !== 4'b0000) begin bad++; $display("FAIL bc_drained got=%b exp=0000", ovalid); end
   endtask

   task automatic test_full_pop_same_cycle();
      dir = 2'd0; valid = 1'b1; data = 32'd1;
      cyc();
      data = 32'd2;
      cyc();
      data = 32'd3; oready = 4'b0001;
      #1;
      total++; if (ready !== 1'b0) begin bad++; $display("FAIL fp_ready got=%b exp=0", ready); end
      total++; if (odata[0 +: 32] !== 32'd1) begin bad++; $display("FAIL fp_order1 got=%0d exp=1", odata[0 +: 32]); end
      cyc();
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL fp_ready_next got=%b exp=1", ready); end
      total++; if (odata[0 +: 32] !== 32'd2) begin bad++; $display("FAIL fp_order2 got=%0d exp=2", odata[0 +: 32]); end
      cyc();
      valid = 1'b0;
      total++; if (ovalid[0] !== 1'b1 || odata[0 +: 32] !== 32'd3) begin
         bad++; $display("FAIL fp_order3 got=%b/%0d exp=1/3", ovalid[0], odata[0 +: 32]);
      end
      cyc();
      oready = 4'b0000;
      total++; if (ovalid !== 4'b0000) begin bad++; $display("FAIL fp_empty got=%b exp=0000", ovalid); end
   endtask

   task automatic test_drop();
      dir3 = 2'd3; valid3 = 1'b1; data = 32'hDEAD;
      #1;
      total++; if (ready3 !== 1'b1) begin bad++; $display("FAIL drop_ready got=%b exp=1", ready3); end
      total++; if (drop3 !== 1'b0) begin bad++; $display("FAIL drop_early got=%b exp=0", drop3); end
      cyc();
      valid3 = 1'b0;
      total++; if (drop3 !== 1'b1) begin bad++; $display("FAIL drop_pulse got=%b exp=1", drop3); end
      total++; if (ovalid3 !== 3'b000) begin bad++; $display("FAIL drop_novalid got=%b exp=000", ovalid3); end
      total++; if (idle3 !== 1'b1) begin bad++; $display("FAIL drop_idle got=%b exp=1", idle3); end
      cyc();
      total++; if (drop3 !== 1'b0) begin bad++; $display("FAIL drop_once got=%b exp=0", drop3); end
      dir3 = 2'd2; valid3 = 1'b1; data = 32'h77;
      cyc();
      valid3 = 1'b0;
      total++; if (ovalid3 !== 3'b100 || odata3[64 +: 32] !== 32'h77 || drop3 !== 1'b0) begin
         bad++; $display("FAIL ch3_route got=%b/%h/%b exp=100/77/0", ovalid3, odata3[64 +: 32], drop3);
      end
   endtask

   task automatic test_reset_mid();
      valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         dir = 2'(i); data = 32'h50 + 32'(i);
         cyc();
      end
      valid = 1'b0;
      total++; if (ovalid !== 4'b0111) begin bad++; $display("FAIL rm_filled got=%b exp=0111", ovalid); end
      #2;
      rst = 1'b1;
      #1;
      total++; if (ovalid !== 4'b0000) begin bad++; $display("FAIL rm_valid got=%b exp=0000", ovalid); end
      total++; if (idle !== 1'b1) begin bad++; $display("FAIL rm_idle got=%b exp=1", idle); end
      total++; if (ovalid3 !== 3'b000) begin bad++; $display("FAIL rm_valid3 got=%b exp=000", ovalid3); end
      cyc();
      rst = 1'b0;
      oready = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         cyc();
         total++; if (ovalid !== 4'b0000 || idle !== 1'b1) begin
            bad++; $display("FAIL rm_stale%0d got=%b/%b exp=0000/1", i, ovalid, idle);
         end
      end
      oready = 4'b0000;
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_broadcast();
      test_full_pop_same_cycle();
      test_drop();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
